// File: rtl/ninjakun_busresp_if.sv
// CPU-side bus between the two-CPU multiplexer (master) and the I/O responder (slave).
interface ninjakun_busresp_if;
    logic [15:0] CPADR;
    logic [7:0]  CPODT;
    logic [7:0]  CPIDT;
    logic        CPRED;
    logic        CPWRT;
    logic        CPSEL;

    modport master (output CPADR, CPODT, CPRED, CPWRT, CPSEL, input CPIDT);
    modport slave  (input  CPADR, CPODT, CPRED, CPWRT, CPSEL, output CPIDT);
endinterface

// File: rtl/ninjakun_busresp.sv
// Bus responder: shared work RAM, scroll/control/status registers, video read port.
// Define NINJAKUN_SCROLL_SHADOW_EN to double-buffer scroll values until vertical blank.
module ninjakun_busresp #(
    parameter int         RAMAW  = 11,
    parameter logic [7:0] RDFILL = 8'hFF
) (
    input  logic             MCLK,
    input  logic             RESET,
    ninjakun_busresp_if.slave bus,
    input  logic             VBLK,
    input  logic [RAMAW-1:0] VRAD,
    output logic [7:0]       VRDT,
    output logic [7:0]       SCRX,
    output logic [7:0]       SCRY,
    output logic             FLIP,
    output logic             BANK
);
    localparam logic [15:0] RAM_BASE = 16'hC000;

    logic [7:0]       mem [2**RAMAW];
    logic             wr_q, rd_q;
    logic             wr_go, rd_go;
    logic             sel_ram, sel_scrx, sel_scry, sel_ctrl, sel_stat;
    logic             pend;
    logic [7:0]       rd_scrx, rd_scry, reg_rdata;
    logic [RAMAW-1:0] ram_addr;

    // One commit/capture per strobe assertion, however long it is held.
    assign wr_go = bus.CPSEL & bus.CPWRT & ~wr_q;
    assign rd_go = bus.CPSEL & bus.CPRED & ~rd_q;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= bus.CPSEL & bus.CPWRT;
            rd_q <= bus.CPSEL & bus.CPRED;
        end
    end

    assign ram_addr = bus.CPADR[RAMAW-1:0];
    assign sel_ram  = (bus.CPADR[15:RAMAW] == RAM_BASE[15:RAMAW]);
    assign sel_scrx = (bus.CPADR == 16'hA000);
    assign sel_scry = (bus.CPADR == 16'hA001);
    assign sel_ctrl = (bus.CPADR == 16'hA002);
    assign sel_stat = (bus.CPADR == 16'hA003);

    always_ff @(posedge MCLK) begin
        if (wr_go && sel_ram)
            mem[ram_addr] <= bus.CPODT;
    end

    // Video port reads every cycle; a same-cycle CPU write is seen one cycle later.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) VRDT <= 8'h00;
        else       VRDT <= mem[VRAD];
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            FLIP <= 1'b0;
            BANK <= 1'b0;
        end else if (wr_go && sel_ctrl) begin
            FLIP <= bus.CPODT[0];
            BANK <= bus.CPODT[1];
        end
    end

`ifdef NINJAKUN_SCROLL_SHADOW_EN
    logic [7:0] pscrx, pscry;
    logic       vblk_q, vb_rise;

    assign vb_rise = VBLK & ~vblk_q;

    // Copy uses pre-write pending values, so a collision keeps the new value pending.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            vblk_q <= 1'b0;
            pscrx  <= 8'h00;
            pscry  <= 8'h00;
            SCRX   <= 8'h00;
            SCRY   <= 8'h00;
            pend   <= 1'b0;
        end else begin
            vblk_q <= VBLK;
            if (vb_rise && pend) begin
                SCRX <= pscrx;
                SCRY <= pscry;
            end
            if (wr_go && sel_scrx) pscrx <= bus.CPODT;
            if (wr_go && sel_scry) pscry <= bus.CPODT;
            if (wr_go && (sel_scrx || sel_scry))
                pend <= 1'b1;
            else if (vb_rise)
                pend <= 1'b0;
        end
    end

    assign rd_scrx = pscrx;
    assign rd_scry = pscry;
`else
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            SCRX <= 8'h00;
            SCRY <= 8'h00;
        end else begin
            if (wr_go && sel_scrx) SCRX <= bus.CPODT;
            if (wr_go && sel_scry) SCRY <= bus.CPODT;
        end
    end

    assign pend    = 1'b0;
    assign rd_scrx = SCRX;
    assign rd_scry = SCRY;
`endif

    always_comb begin
        reg_rdata = RDFILL;
        if (sel_scrx)      reg_rdata = rd_scrx;
        else if (sel_scry) reg_rdata = rd_scry;
        else if (sel_ctrl) reg_rdata = {6'b0, BANK, FLIP};
        else if (sel_stat) reg_rdata = {6'b0, pend, VBLK};
    end

    // Read data is captured at the strobe edge and held until the next one.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET)      bus.CPIDT <= 8'hFF;
        else if (rd_go) bus.CPIDT <= sel_ram ? mem[ram_addr] : reg_rdata;
    end
endmodule

// File: tb/tb_ninjakun_busresp.sv
// Randomized bench for ninjakun_busresp against a transaction-level model.
module tb_ninjakun_busresp;
    localparam int RAMAW = 11;
`ifdef NINJAKUN_SCROLL_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic             MCLK = 1'b0;
    logic             RESET = 1'b1;
    logic             VBLK = 1'b0;
    logic [RAMAW-1:0] VRAD = '0;
    logic [7:0]       VRDT, SCRX, SCRY;
    logic             FLIP, BANK;

    ninjakun_busresp_if bus ();

    ninjakun_busresp #(.RAMAW(RAMAW), .RDFILL(8'hFF)) dut (
        .MCLK(MCLK), .RESET(RESET), .bus(bus), .VBLK(VBLK), .VRAD(VRAD),
        .VRDT(VRDT), .SCRX(SCRX), .SCRY(SCRY), .FLIP(FLIP), .BANK(BANK)
    );

    always #5 MCLK = ~MCLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model state
    logic [7:0] mem_m [2**RAMAW];
    logic [7:0] scrx_m, scry_m, pscrx_m, pscry_m, last_rd;
    bit         pend_m, flip_m, bank_m;

    logic [15:0] ram_pool [8] = '{16'hC000, 16'hC001, 16'hC123, 16'hC3FF,
                                  16'hC400, 16'hC555, 16'hC7FE, 16'hC7FF};
    logic [15:0] unm_pool [8] = '{16'hB000, 16'hA004, 16'h9FFF, 16'hC800,
                                  16'h0000, 16'hFFFF, 16'hBFFF, 16'hA0FF};

    function automatic bit is_ram(input logic [15:0] a);
        return (a >= 16'hC000) && (a <= 16'hC7FF);
    endfunction

    task automatic m_reset();
        scrx_m = 0; scry_m = 0; pscrx_m = 0; pscry_m = 0;
        pend_m = 0; flip_m = 0; bank_m = 0; last_rd = 8'hFF;
    endtask

    task automatic m_write(input logic [15:0] a, input logic [7:0] d);
        if (is_ram(a)) mem_m[a - 16'hC000] = d;
        else if (a == 16'hA000) begin
            if (SHADOW) begin pscrx_m = d; pend_m = 1; end else scrx_m = d;
        end else if (a == 16'hA001) begin
            if (SHADOW) begin pscry_m = d; pend_m = 1; end else scry_m = d;
        end else if (a == 16'hA002) begin
            flip_m = d[0]; bank_m = d[1];
        end
    endtask

    task automatic m_vblank();
        if (SHADOW && pend_m) begin
            scrx_m = pscrx_m; scry_m = pscry_m; pend_m = 0;
        end
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (is_ram(a)) return mem_m[a - 16'hC000];
        case (a)
            16'hA000: return SHADOW ? pscrx_m : scrx_m;
            16'hA001: return SHADOW ? pscry_m : scry_m;
            16'hA002: return {6'b0, bank_m, flip_m};
            16'hA003: return {6'b0, pend_m, VBLK};
            default:  return 8'hFF;
        endcase
    endfunction

    task automatic idle();
        @(posedge MCLK); #1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".scrx"}, SCRX, scrx_m);
        chk({tag, ".scry"}, SCRY, scry_m);
        chk({tag, ".flip"}, FLIP, flip_m);
        chk({tag, ".bank"}, BANK, bank_m);
    endtask

    // Data is changed after the first edge so only an edge-triggered commit matches.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                             input bit sel, input bit vb);
        bus.CPADR = a; bus.CPODT = d; bus.CPSEL = sel; bus.CPWRT = 1'b1;
        if (vb) VBLK = 1'b1;
        idle();
        if (vb) m_vblank();
        if (sel) m_write(a, d);
        bus.CPODT = ~d;
        repeat (hold - 1) idle();
        bus.CPWRT = 1'b0; bus.CPSEL = 1'b0; bus.CPODT = 8'($urandom);
        VBLK = 1'b0;
        idle();
        check_outs("wr");
        chk("wr.cpidt_hold", bus.CPIDT, last_rd);
    endtask

    task automatic bus_read(input logic [15:0] a, input int hold);
        logic [7:0] exp;
        exp = m_read(a);
        bus.CPADR = a; bus.CPSEL = 1'b1; bus.CPRED = 1'b1;
        idle();
        chk("rd.first", bus.CPIDT, exp);
        bus.CPADR = ram_pool[$urandom_range(0, 7)];
        repeat (hold - 1) idle();
        bus.CPRED = 1'b0; bus.CPSEL = 1'b0;
        idle();
        chk("rd.held", bus.CPIDT, exp);
        last_rd = exp;
    endtask

    task automatic vblank_pulse();
        VBLK = 1'b1;
        idle();
        m_vblank();
        check_outs("vb");
        bus_read(16'hA003, 1);
        VBLK = 1'b0;
        idle();
    endtask

    task automatic video_chk(input logic [15:0] a);
        VRAD = a[RAMAW-1:0];
        idle();
        chk("video", VRDT, mem_m[a - 16'hC000]);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 9))
            5:       return 16'hA000;
            6:       return 16'hA001;
            7:       return 16'hA002;
            8:       return 16'hA003;
            9:       return unm_pool[$urandom_range(0, 7)];
            default: return ram_pool[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        bus.CPADR = 0; bus.CPODT = 0; bus.CPSEL = 0; bus.CPRED = 0; bus.CPWRT = 0;
        m_reset();
        #23 RESET = 1'b0;
        idle();
        check_outs("rst");
        chk("rst.cpidt", bus.CPIDT, 8'hFF);
        chk("rst.vrdt", VRDT, 8'h00);

        // Dirty state, then asynchronous reset mid-cycle
        bus_write(16'hA002, 8'h03, 1, 1, 0);
        bus_write(16'hA000, 8'h5C, 1, 1, 0);
        bus_read(16'hA002, 1);
        #2 RESET = 1'b1;
        #1 m_reset();
        check_outs("arst");
        chk("arst.cpidt", bus.CPIDT, 8'hFF);
        idle();
        RESET = 1'b0;
        idle();
        bus_read(16'hA003, 1);
        chk("arst.status", bus.CPIDT, 8'h00);

        // RAM round trip with held strobes
        bus_write(16'hC123, 8'h5A, 4, 1, 0);
        bus_read(16'hC123, 3);
        video_chk(16'hC123);

        // Scroll write then vblank apply
        bus_write(16'hA000, 8'h37, 1, 1, 0);
        bus_read(16'hA003, 1);
        vblank_pulse();

        // Scroll write colliding with vblank rise
        bus_write(16'hA000, 8'h10, 1, 1, 0);
        bus_write(16'hA000, 8'h20, 2, 1, 1);
        bus_read(16'hA000, 1);
        bus_read(16'hA003, 1);
        vblank_pulse();

        // Unmapped reads and deselected writes
        bus_write(16'hC000, 8'hAA, 1, 1, 0);
        bus_read(16'hB000, 2);
        chk("unmapped", bus.CPIDT, 8'hFF);
        bus_write(16'hC000, 8'h55, 2, 0, 0);
        bus_read(16'hC000, 1);

        // Control register
        bus_write(16'hA002, 8'h03, 1, 1, 0);
        bus_read(16'hA002, 1);

        // Random traffic; initialise the RAM pool first
        foreach (ram_pool[i]) bus_write(ram_pool[i], 8'($urandom), 1, 1, 0);
        for (int i = 0; i < 200; i++) begin
            a = pick_addr();
            case ($urandom_range(0, 5))
                0, 1: bus_write(a, 8'($urandom), $urandom_range(1, 4), ($urandom_range(0, 7) != 0), 0);
                2, 3: bus_read(a, $urandom_range(1, 4));
                4:    vblank_pulse();
                default: video_chk(ram_pool[$urandom_range(0, 7)]);
            endcase
        end
        bus_write(16'hA001, 8'h6E, 1, 1, ($urandom_range(0, 1) == 1));
        vblank_pulse();

        // Strobe held across reset release is serviced once
        RESET = 1'b1;
        bus.CPADR = 16'hC7FF; bus.CPODT = 8'h77; bus.CPSEL = 1'b1; bus.CPWRT = 1'b1;
        idle();
        m_reset();
        mem_m[16'h07FF] = 8'h77;
        idle();
        RESET = 1'b0;
        repeat (3) idle();
        bus.CPWRT = 1'b0; bus.CPSEL = 1'b0;
        idle();
        check_outs("rst_strobe");
        bus_read(16'hC7FF, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ninjakun_busresp.md
Name: ninjakun_busresp

Overview:
- Responder (target) end of the shared CPU I/O bus that the two-CPU multiplexer drives (CPADR/CPODT/CPRED/CPWRT/CPSEL).
- Hosts 2 KB shared work RAM, scroll/control registers and a status register.
- Returns registered read data on CPIDT.
- Exposes a second RAM read port and the scroll/control state to the video pipeline.
- Scroll values are double-buffered and applied at vertical blank.

Parameters:
- RAMAW, 11, work-RAM address width (2^RAMAW bytes, mapped at 0xC000).
- RDFILL, 8'hFF, read data returned for unmapped addresses.

Ports:
- MCLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPADR  in  16  bus address from the CPU multiplexer.
- CPODT  in  8  bus write data.
- CPIDT  out  8  bus read data (registered).
- CPRED  in  1  read strobe; may stay high for several MCLK cycles.
- CPWRT  in  1  write strobe; may stay high for several MCLK cycles.
- CPSEL  in  1  bus cycle owned by the responder; qualifies CPRED/CPWRT.
- VBLK  in  1  vertical blank level, synchronous to MCLK.
- VRAD  in  RAMAW  video-side RAM read address.
- VRDT  out  8  video-side RAM data, 1-cycle latency.
- SCRX  out  8  active horizontal scroll.
- SCRY  out  8  active vertical scroll.
- FLIP  out  1  screen flip (control bit0).
- BANK  out  1  video bank select (control bit1).

Behaviour:
- Address map (decoded only when CPSEL=1):
  - 0xC000–0xC7FF: RAM.
  - 0xA000: SCRX.
  - 0xA001: SCRY.
  - 0xA002: CTRL.
  - 0xA003: STATUS (read-only).
  - Anything else is unmapped.
- Reset: CPIDT=8'hFF; SCRX/SCRY and pending copies =0; FLIP=0; BANK=0; pending flag=0; VRDT=0. RAM contents are not cleared.
- Strobe edge detection:
  - wr_go = CPSEL & CPWRT & ~wr_q; rd_go = CPSEL & CPRED & ~rd_q.
  - wr_q/rd_q register (CPSEL&CPWRT) and (CPSEL&CPRED).
  - Exactly one write commit and one read capture per strobe assertion, however long the strobe is held.
- Write (cycle of wr_go):
  - RAM: byte written at CPADR[RAMAW-1:0].
  - 0xA000/0xA001: CPODT loaded into PSCRX/PSCRY; pending flag set.
  - 0xA002: FLIP<=CPODT[0], BANK<=CPODT[1] immediately.
  - STATUS and unmapped addresses: write ignored.
- Read:
  - CPIDT updated on the cycle after rd_go; held until the next rd_go.
  - RAM: data at address sampled at rd_go.
  - 0xA000/0xA001: pending (not active) scroll value.
  - 0xA002: {6'b0,BANK,FLIP}.
  - 0xA003: {6'b0,pending,VBLK}.
  - Unmapped: RDFILL.
- Read-after-write to the same RAM address on back-to-back strobes returns the new data. The RAM is true dual-port; the CPU port is read-first only within one cycle, and that case cannot occur because a strobe pair is always ≥2 cycles apart.
- Vblank apply:
  - vb_rise = VBLK & ~VBLK_q.
  - On vb_rise with pending=1: SCRX<=PSCRX, SCRY<=PSCRY, pending<=0.
  - wr_go to a scroll register in the same cycle as vb_rise: the copy uses the pre-write pending value; the new value lands in pending; pending stays 1.
- Video port: VRDT <= RAM[VRAD] every cycle, independent of bus activity. A same-address CPU write in the same cycle returns old data.
- Reset mid-strobe: the edge detectors clear, so a strobe still high when RESET releases counts as a new edge and is serviced once.

Optional Feature:
- NINJAKUN_SCROLL_SHADOW_EN:
  - Defined: double-buffered scroll as described above.
  - Undefined: scroll writes load SCRX/SCRY directly in the cycle after wr_go; pending flag is tied 0; reads of 0xA000/0xA001 return the active value; VBLK is used only for STATUS bit0.

Test Plan:
- Reset: assert RESET async mid-cycle → CPIDT=FF, SCRX=SCRY=00, FLIP=BANK=0, STATUS read=8'h00 with VBLK=0.
- RAM round-trip: write 5A to C123 with CPWRT held 4 cycles, then read C123 → one RAM write, CPIDT=5A one cycle after read edge; VRAD=123 gives VRDT=5A next cycle.
- Shadow: write A000=37 → SCRX stays 00, STATUS=02; raise VBLK → SCRX=37 next cycle, STATUS=01.
- Collision: pending=1 (PSCRX=10); write A000=20 on the same cycle as the VBLK rise → SCRX=10, PSCRX=20, pending=1.
- Unmapped and selection: read 0xB000 → FF; write C000 with CPSEL=0 → RAM unchanged, CPIDT unchanged.
- Control: write A002=03 → FLIP=1, BANK=1 next cycle; readback 03.
